hash_store_sequencer: RTL and testbench
=======================================

# hash_store_sequencer

Parametrised digest store sequencer for the SHA datapath. On a start pulse it captures a full digest and streams it word by word into the hash output memory. Writes honour a ready/backpressure handshake, start from a programmable base address, and follow a selectable word order. A one-cycle completion pulse is raised after the last word is accepted. The block sits between the compression core's final hash vector and the output memory write port.

## Interface
- DIGEST_WIDTH, 256: digest bits captured per start (256 for SHA-256, 224 for SHA-224); multiple of WORD_WIDTH
- WORD_WIDTH, 32: bits per memory word written
- ADDR_WIDTH, 8: memory address width
- WORD_ORDER, 0: 0 = word 0 is digest bits [WORD_WIDTH-1:0]; 1 = word 0 is the most-significant word
- NUM_WORDS (localparam): DIGEST_WIDTH/WORD_WIDTH; IDX_W = max(1, $clog2(NUM_WORDS))

- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; asserted low clears all state immediately
- start  in  1  request to store hash_vector; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE without completion
- hash_vector  in  DIGEST_WIDTH  digest; captured on the accepted start edge
- base_address  in  ADDR_WIDTH  address of word 0; captured with hash_vector
- h_write_ready  in  1  memory accepts the current word this cycle
- h_write  out  1  word valid on h_data/h_output_address
- h_data  out  WORD_WIDTH  current word
- h_output_address  out  ADDR_WIDTH  base_address + word index, modulo 2^ADDR_WIDTH
- h_vector_complete  out  1  one-cycle pulse after the last word is accepted
- busy  out  1  high in WRITE and DONE

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: if start=1 and abort=0:
  - capture hash_vector into the shadow register and base_address into the base register;
  - clear the index to 0;
  - go to WRITE.
- WRITE: h_write=1 and h_data = shadow word selected by index and WORD_ORDER.
  - Order 0: word k = shadow[k*WORD_WIDTH +: WORD_WIDTH].
  - Order 1: word k = shadow[(NUM_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH].
  - A word is accepted when h_write and h_write_ready are both 1 at a rising edge.
  - On acceptance with index < NUM_WORDS-1: increment the index.
  - On acceptance with index = NUM_WORDS-1: go to DONE.
- DONE: h_vector_complete=1, h_write=0 for one cycle; then go to IDLE.
- abort=1 in any state: go to IDLE at the next edge.
  - h_write drops and no completion pulse is issued.
  - abort takes priority over acceptance and over start.
- start outside IDLE is ignored; it is not queued.
- Shadow and base registers are held while busy, so hash_vector may change after the start edge.
- Address arithmetic is ADDR_WIDTH bits wide and wraps: base 0xFE with 8 words gives 0xFE, 0xFF, 0x00 … 0x05.

## Timing
- Reset values (asynchronous, reset=0): state IDLE, index 0, h_write 0, h_vector_complete 0, busy 0, h_data 0, h_output_address 0, shadow and base registers 0.
- Reset deassertion is synchronised by the system; the first active edge after release sees IDLE.
- Start sampled at edge E: h_write=1 with word 0 during the cycle after E.
- With h_write_ready held at 1:
  - one word is accepted per cycle;
  - the last word is accepted at edge E+NUM_WORDS;
  - h_vector_complete is high during the cycle after that edge;
  - the block is back in IDLE one edge later.
- Minimum start-to-start spacing is NUM_WORDS+2 cycles.
- Backpressure: while h_write=1 and h_write_ready=0, h_data and h_output_address stay stable and h_write stays 1.
- h_write_ready may toggle every cycle; each accepted word advances the index by exactly one.
- h_data and h_output_address are registered outputs; they hold their last value in IDLE and DONE.
- Reset mid-write: outputs clear at once, no completion pulse, the next start begins again at word 0.

## Test plan
- Default parameters, hash_vector = 0x…_77777777_66666666_…_00000000 (word k = k repeated in every nibble), base 0x10, ready=1 -> addresses 0x10–0x17 hold words 0…7 on eight consecutive cycles, then one h_vector_complete pulse; busy is high for 9 cycles.
- Same digest, WORD_ORDER=1 -> address 0x10 receives 0x77777777 and address 0x17 receives 0x00000000.
- Ready pattern 1,0,0,1,0,1… -> no word dropped or duplicated, data and address stable during stalls, completion pulse only after the 8th acceptance.
- Base 0xFE -> address sequence 0xFE, 0xFF, 0x00 … 0x05.
- Abort during word 3, and separately reset low during word 5 -> h_write drops, no completion pulse; a fresh start writes all 8 words from word 0.
- DIGEST_WIDTH=224 -> 7 writes, completion pulse on the 8th cycle after start; a start pulsed while busy is ignored.

Source files
------------

// File: rtl/hash_store_sequencer.sv
// Digest store sequencer: captures a hash vector on start and streams it
// word by word to the output memory under a ready handshake.
module hash_store_sequencer #(
  parameter int DIGEST_WIDTH = 256,
  parameter int WORD_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WORD_ORDER   = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIGEST_WIDTH-1:0] hash_vector,
  input  logic [ADDR_WIDTH-1:0]   base_address,
  input  logic                    h_write_ready,
  output logic                    h_write,
  output logic [WORD_WIDTH-1:0]   h_data,
  output logic [ADDR_WIDTH-1:0]   h_output_address,
  output logic                    h_vector_complete,
  output logic                    busy
);

  localparam int NUM_WORDS = DIGEST_WIDTH / WORD_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIGEST_WIDTH-1:0] shadow_q, shadow_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    write_q, write_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [IDX_W-1:0]        idx_nx;
  logic                    accept;

  function automatic logic [WORD_WIDTH-1:0] pick(
    input logic [DIGEST_WIDTH-1:0] v,
    input logic [IDX_W-1:0]        k
  );
    int s;
    s = (WORD_ORDER != 0) ? (NUM_WORDS - 1 - int'(k)) : int'(k);
    return v[s*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  assign idx_nx = idx_q + 1'b1;
  assign accept = write_q & h_write_ready;

  // Outputs are computed one edge ahead so every port is a flop.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    base_d   = base_q;
    write_d  = write_q;
    data_d   = data_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    if (abort) begin
      state_d = IDLE;
      write_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = WRITE;
            shadow_d = hash_vector;
            base_d   = base_address;
            idx_d    = '0;
            write_d  = 1'b1;
            busy_d   = 1'b1;
            data_d   = pick(hash_vector, '0);
            addr_d   = base_address;
          end
        end
        WRITE: begin
          if (accept) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              write_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d  = idx_nx;
              data_d = pick(shadow_q, idx_nx);
              addr_d = base_q + ADDR_WIDTH'(idx_nx);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          write_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      base_q   <= '0;
      write_q  <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      base_q   <= base_d;
      write_q  <= write_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign h_write           = write_q;
  assign h_data            = data_q;
  assign h_output_address  = addr_q;
  assign h_vector_complete = done_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_hash_store_sequencer.sv
// Directed bench: default, reversed-order and 224-bit sequencers
// driven in lockstep and checked each cycle.
module tb_hash_store_sequencer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [255:0] hv;
  logic [7:0]   base;
  logic         rdy;

  logic         hw [3];
  logic [31:0]  hd [3];
  logic [7:0]   ha [3];
  logic         hc [3];
  logic         hb [3];

  int nvec;
  int nerr;

  int           st  [3];
  int           idx [3];
  logic [255:0] mhv [3];
  logic [7:0]   mb  [3];
  int           nw  [3];

  hash_store_sequencer u0 (
    .clock(clk), .reset(rst_n), .start(start), .abort(abort),
    .hash_vector(hv), .base_address(base), .h_write_ready(rdy),
    .h_write(hw[0]), .h_data(hd[0]), .h_output_address(ha[0]),
    .h_vector_complete(hc[0]), .busy(hb[0])
  );

  hash_store_sequencer #(.WORD_ORDER(1)) u1 (
    .clock(clk), .reset(rst_n), .start(start), .abort(abort),
    .hash_vector(hv), .base_address(base), .h_write_ready(rdy),
    .h_write(hw[1]), .h_data(hd[1]), .h_output_address(ha[1]),
    .h_vector_complete(hc[1]), .busy(hb[1])
  );

  hash_store_sequencer #(.DIGEST_WIDTH(224)) u2 (
    .clock(clk), .reset(rst_n), .start(start), .abort(abort),
    .hash_vector(hv[223:0]), .base_address(base), .h_write_ready(rdy),
    .h_write(hw[2]), .h_data(hd[2]), .h_output_address(ha[2]),
    .h_vector_complete(hc[2]), .busy(hb[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    int s;
    s = (i == 1) ? (7 - idx[i]) : idx[i];
    return mhv[i][s*32 +: 32];
  endfunction

  task automatic chk_all(input string tag);
    logic [7:0] a;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s u%0d write", tag, i), 32'(hw[i]), 32'(st[i] == 1));
      chk($sformatf("%s u%0d cpl", tag, i), 32'(hc[i]), 32'(st[i] == 2));
      chk($sformatf("%s u%0d busy", tag, i), 32'(hb[i]), 32'(st[i] != 0));
      if (st[i] == 1) begin
        a = mb[i] + 8'(idx[i]);
        chk($sformatf("%s u%0d data", tag, i), hd[i], exp_word(i));
        chk($sformatf("%s u%0d addr", tag, i), 32'(ha[i]), 32'(a));
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s u%0d write", tag, i), 32'(hw[i]), 32'd0);
      chk($sformatf("%s u%0d cpl", tag, i), 32'(hc[i]), 32'd0);
      chk($sformatf("%s u%0d busy", tag, i), 32'(hb[i]), 32'd0);
      chk($sformatf("%s u%0d data", tag, i), hd[i], 32'd0);
      chk($sformatf("%s u%0d addr", tag, i), 32'(ha[i]), 32'd0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      st[i]  = 0;
      idx[i] = 0;
    end
  endtask

  task automatic step();
    for (int i = 0; i < 3; i++) begin
      if (abort) st[i] = 0;
      else if (st[i] == 0) begin
        if (start) begin
          st[i]  = 1;
          idx[i] = 0;
          mhv[i] = hv;
          mb[i]  = base;
        end
      end else if (st[i] == 1) begin
        if (rdy) begin
          if (idx[i] == nw[i] - 1) st[i] = 2;
          else idx[i]++;
        end
      end else st[i] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_full(input string tag);
    rdy   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      chk_all(tag);
      step();
    end
    chk_all(tag);
  endtask

  logic [255:0] pat_hv;
  logic         pat [6];

  initial begin
    nvec  = 0;
    nerr  = 0;
    nw[0] = 8;
    nw[1] = 8;
    nw[2] = 7;
    for (int k = 0; k < 8; k++)
      pat_hv[k*32 +: 32] = 32'h11111111 * k;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      mhv[i] = '0;
      mb[i]  = '0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    rdy   = 1'b0;
    hv    = pat_hv;
    base  = 8'h10;
    #3;
    chk_reset("por");
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("idle");

    // Full stream, plus a start while busy that must be ignored
    rdy   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1 u0 w0", hd[0], 32'h00000000);
    chk("t1 u1 w0", hd[1], 32'h77777777);
    chk("t1 u0 a0", 32'(ha[0]), 32'h10);
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        start = 1'b1;
        hv    = ~pat_hv;
      end
      if (c == 3) begin
        start = 1'b0;
        hv    = pat_hv;
      end
      if (c == 7) begin
        chk("t1 u2 cpl8", 32'(hc[2]), 32'd1);
        chk("t1 u1 a17", 32'(ha[1]), 32'h17);
        chk("t1 u1 w7", hd[1], 32'h00000000);
      end
      chk_all("stream");
      step();
    end

    // Backpressure pattern 1,0,0,1,0,1
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      rdy = pat[c % 6];
      chk_all("bp");
      step();
    end
    chk_all("bp_end");

    // Address wrap from 0xFE
    base  = 8'hFE;
    rdy   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c == 2) chk("wrap a2", 32'(ha[0]), 32'h00);
      if (c == 7) chk("wrap a7", 32'(ha[0]), 32'h05);
      chk_all("wrap");
      step();
    end

    // Abort while word 3 is presented
    base  = 8'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_all("pre_abort");
      step();
    end
    chk("abort w3", hd[0], 32'h33333333);
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_all("post_abort");
      step();
    end
    run_full("after_abort");

    // Reset while word 5 is presented
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_all("pre_rst");
      step();
    end
    chk("rst w5", hd[0], 32'h55555555);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    model_reset();
    rst_n = 1'b1;
    step();
    chk_all("post_rst");
    step();
    chk_all("post_rst2");
    run_full("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
